sobel_grad_sq: RTL and testbench
================================

Name: sobel_grad_sq

Overview:
- Streaming Sobel gradient stage sitting directly upstream of the approximate square-root block.
- Accepts a raster-order 8-bit grayscale pixel stream and forms a 3x3 window from two line buffers.
- For each interior pixel it computes Gx and Gy, scales them, and emits the 16-bit radicand Gx'^2 + Gy'^2 consumed by squareroot_MAHSQR_k8 (R input).

Parameters:
- IMG_W, 64, pixels per line (min 3, max 1024).
- IMG_H, 48, lines per frame (min 3, max 1024).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pix_valid  input  1  pix_data/pix_sof valid this cycle; no backpressure.
- pix_sof  input  1  qualifies the first pixel (row 0, col 0) of a frame.
- pix_data  input  8  unsigned grayscale pixel.
- rad_valid  output  1  rad_data valid this cycle.
- rad_data  output  16  unsigned radicand, Gx'^2 + Gy'^2.
- rad_last  output  1  asserted with the final radicand of a frame.
- sof_err  output  1  one-cycle pulse when pix_sof arrives before the previous frame completes.

Behaviour:
- Reset (async, rst_n=0): rad_valid=0, rad_data=0, rad_last=0, sof_err=0; col/row counters=0; pipeline valids cleared; line-buffer contents don't-care.
- Frame state is tracked by col (0..IMG_W-1) and row (0..IMG_H-1) counters, advancing only on pix_valid.
  - col wraps to 0 after IMG_W-1 and increments row.
  - row wraps to 0 after IMG_H-1 together with col.
- State machine: IDLE -> STREAM -> IDLE.
  - IDLE: pixels without pix_sof are dropped.
  - IDLE, pix_valid & pix_sof: accept the pixel as (0,0) and go to STREAM.
  - STREAM: returns to IDLE after accepting pixel (IMG_H-1, IMG_W-1).
  - STREAM, pix_sof: sof_err pulses, counters restart with this pixel as (0,0), and in-flight pipeline results are still delivered. rad_last is not issued for the aborted frame.
- Window: two line buffers of depth IMG_W plus a 3x3 register window.
  - Accepting pixel (r,c) with r>=2 and c>=2 produces the window centred at (r-1,c-1).
  - Only interior centres are output. Count per frame = (IMG_W-2)*(IMG_H-2).
  - No border padding.
- Kernels (window rows t/m/b, columns l/c/r):
  - Gx = (tr + 2*mr + br) - (tl + 2*ml + bl).
  - Gy = (bl + 2*bc + br) - (tl + 2*tc + tr).
  - Gx and Gy are 11-bit signed, range -1020..1020.
- Scaling: Gx' = |Gx| >> 3 and Gy' = |Gy| >> 3, 7-bit unsigned, 0..127.
  - Squares are 14-bit.
  - The sum is at most 32258, so rad_data[15] is always 0 and no saturation logic exists.
- Pipeline, fixed latency 2 cycles:
  - S1 registers Gx' and Gy'.
  - S2 registers rad_data.
  - rad_valid is asserted exactly 2 clk cycles after the clk edge that accepts the qualifying pixel.
- pix_valid gaps: the pipeline advances every cycle regardless of input gaps. Gaps produce rad_valid=0 bubbles; no data is held.
- rad_data holds its last value when rad_valid=0.
- rad_last: asserted with the radicand whose window completes on pixel (IMG_H-1, IMG_W-1).
- Reset mid-frame: all counters and valids clear immediately. The next frame requires pix_sof.

Decomposition:
- Package sobel_pkg holds:
  - PIX_W=8, GRAD_W=11, SCALE_SH=3, MAG_W=7, RAD_W=16.
  - The state enum {IDLE, STREAM}.
- Sub-module sobel_line_buffer (parameter DEPTH, WIDTH=8): shift-enable delay line, output = input delayed DEPTH enabled cycles.
  - Two instances, chained.

Test Plan:
- Uniform frame, all pixels 100, IMG_W=8, IMG_H=6 -> 24 radicands, all 0; rad_last on the 24th only.
- Vertical step: cols 0-3 = 0, cols 4-7 = 255 -> centres at cols 3 and 4 give Gx=1020, Gx'=127, rad_data=16129; all other centres give 0.
- Horizontal step: rows 0-2 = 0, rows 3-5 = 255 -> centres at rows 2 and 3 give rad_data=16129; others give 0.
- Diagonal edge (pixel = 255 where col > row, else 0) -> every rad_data <= 32258 and rad_data[15]=0; latency is exactly 2 cycles after each qualifying pixel.
- Random pix_valid gaps (~30% idle) on the vertical-step frame -> identical radicand sequence as the gap-free run; exactly 24 rad_valid pulses.
- Mid-frame events:
  - pix_sof at row 3 -> sof_err pulses once and the following full frame is output correctly.
  - rst_n low at row 2 -> all outputs 0 immediately; pixels without pix_sof are ignored until the next pix_sof.

Source files
------------

// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared widths, the frame state enum and small arithmetic helpers used by the
// Sobel gradient-magnitude-squared stage.
//   PIX_W    : input pixel width
//   GRAD_W   : signed Sobel gradient width (-1020..1020)
//   SCALE_SH : right shift applied to |G| before squaring
//   MAG_W    : scaled gradient magnitude width (0..127)
//   RAD_W    : radicand width handed to the square-root stage
// -----------------------------------------------------------------------------
package sobel_pkg;

    localparam int PIX_W    = 8;
    localparam int GRAD_W   = 11;
    localparam int SCALE_SH = 3;
    localparam int MAG_W    = 7;
    localparam int RAD_W    = 16;

    // a + 2*b + c of three pixels; max 1020, so two extra bits suffice.
    localparam int SUM_W    = PIX_W + 2;
    localparam int SQ_W     = 2 * MAG_W;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Weighted column/row sum of one kernel side: a + 2*b + c.
    function automatic logic [SUM_W-1:0] wsum(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] b,
        input logic [PIX_W-1:0] c
    );
        return SUM_W'(a) + {1'b0, b, 1'b0} + SUM_W'(c);
    endfunction

    // Signed difference of the positive and negative kernel sides.
    function automatic logic signed [GRAD_W-1:0] grad(
        input logic [SUM_W-1:0] pos,
        input logic [SUM_W-1:0] neg
    );
        return $signed({1'b0, pos}) - $signed({1'b0, neg});
    endfunction

    // |g| >> SCALE_SH. |g| <= 1020 so the result always fits MAG_W bits.
    function automatic logic [MAG_W-1:0] abs_scale(
        input logic signed [GRAD_W-1:0] g
    );
        logic [GRAD_W-1:0] a;
        a = g[GRAD_W-1] ? GRAD_W'(-g) : GRAD_W'(g);
        return MAG_W'(a >> SCALE_SH);
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// -----------------------------------------------------------------------------
// sobel_line_buffer
// Enable-gated delay line: dout is the din value written DEPTH enabled cycles
// earlier. Implemented as a circular buffer so it maps onto RAM; only the
// pointer is reset, the storage contents are don't-care after reset.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (pointer only)
//   en    : shift enable (one accepted pixel)
//   din   : sample written this enabled cycle
//   dout  : sample written DEPTH enabled cycles ago
// -----------------------------------------------------------------------------
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    // The slot about to be overwritten holds the oldest sample.
    assign dout = mem[ptr];

endmodule

// File: rtl/sobel_grad_sq.sv
// -----------------------------------------------------------------------------
// sobel_grad_sq
// Streaming Sobel stage: builds a 3x3 window over a raster 8-bit pixel stream,
// computes Gx/Gy for every interior centre, scales |G| >> 3 and emits the
// radicand Gx'^2 + Gy'^2 for the downstream square-root block.
//
// Handshake: valid-only streaming, no backpressure. A pixel is transferred on
// every rising edge where pix_valid=1; a radicand is transferred on every edge
// where rad_valid=1. Neither side can stall the other.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   pix_valid  : pix_data/pix_sof valid this cycle
//   pix_sof    : marks pixel (0,0) of a frame
//   pix_data   : unsigned grayscale pixel
//   rad_valid  : rad_data valid this cycle (2 cycles after the qualifying pixel)
//   rad_data   : unsigned radicand; holds its value while rad_valid=0
//   rad_last   : with the final radicand of a completed frame
//   sof_err    : one-cycle pulse when pix_sof arrives mid-frame
// -----------------------------------------------------------------------------
module sobel_grad_sq
    import sobel_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [PIX_W-1:0] pix_data,
    output logic             rad_valid,
    output logic [RAD_W-1:0] rad_data,
    output logic             rad_last,
    output logic             sof_err
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    // ---------------------------------------------------------------------
    // Frame tracking FSM and position counters
    // ---------------------------------------------------------------------
    state_t           state, state_nxt;
    logic [COL_W-1:0] col, col_nxt, cur_col;
    logic [ROW_W-1:0] row, row_nxt, cur_row;
    logic             accept;   // pixel enters the window this cycle
    logic             restart;  // pix_sof seen while a frame is in progress
    logic             at_last;  // accepted pixel is (IMG_H-1, IMG_W-1)
    logic             qualify;  // accepted pixel completes an interior window

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        accept    = 1'b0;
        restart   = 1'b0;
        at_last   = 1'b0;
        qualify   = 1'b0;
        cur_col   = col;
        cur_row   = row;

        case (state)
            IDLE: begin
                // Anything before a start-of-frame is dropped.
                if (pix_valid && pix_sof) begin
                    accept    = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (pix_valid) begin
                    accept  = 1'b1;
                    restart = pix_sof;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A start-of-frame pixel is always (0,0), even mid-frame.
        if (pix_sof) begin
            cur_col = '0;
            cur_row = '0;
        end

        if (accept) begin
            at_last = (cur_row == ROW_W'(IMG_H - 1)) && (cur_col == COL_W'(IMG_W - 1));
            qualify = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
            if (cur_col == COL_W'(IMG_W - 1)) begin
                col_nxt = '0;
                row_nxt = at_last ? '0 : cur_row + 1'b1;
            end else begin
                col_nxt = cur_col + 1'b1;
                row_nxt = cur_row;
            end
            if (at_last) begin
                state_nxt = IDLE;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Line buffers: lb0 yields the pixel one row up, lb1 two rows up.
    // Each delays by exactly IMG_W accepted pixels, so column alignment
    // survives gaps and mid-frame restarts without any pointer resync.
    // ---------------------------------------------------------------------
    logic [PIX_W-1:0] lb0_q, lb1_q;

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .din   (pix_data),
        .dout  (lb0_q)
    );

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .din   (lb0_q),
        .dout  (lb1_q)
    );

    // ---------------------------------------------------------------------
    // 3x3 window, index 0 = left column, 2 = right (newest) column.
    // Data only; validity is carried separately in win_valid.
    // ---------------------------------------------------------------------
    logic [PIX_W-1:0] win_t [3];
    logic [PIX_W-1:0] win_m [3];
    logic [PIX_W-1:0] win_b [3];
    logic             win_valid, win_last;

    always_ff @(posedge clk) begin
        if (accept) begin
            win_t[0] <= win_t[1];
            win_t[1] <= win_t[2];
            win_t[2] <= lb1_q;
            win_m[0] <= win_m[1];
            win_m[1] <= win_m[2];
            win_m[2] <= lb0_q;
            win_b[0] <= win_b[1];
            win_b[1] <= win_b[2];
            win_b[2] <= pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            win_valid <= qualify;
            win_last  <= at_last;
        end
    end

    // ---------------------------------------------------------------------
    // Gradients from the registered window
    // ---------------------------------------------------------------------
    logic [SUM_W-1:0]         x_pos, x_neg, y_pos, y_neg;
    logic signed [GRAD_W-1:0] gx, gy;

    always_comb begin
        x_pos = wsum(win_t[2], win_m[2], win_b[2]);
        x_neg = wsum(win_t[0], win_m[0], win_b[0]);
        y_pos = wsum(win_b[0], win_b[1], win_b[2]);
        y_neg = wsum(win_t[0], win_t[1], win_t[2]);
        gx    = grad(x_pos, x_neg);
        gy    = grad(y_pos, y_neg);
    end

    // ---------------------------------------------------------------------
    // S1: scaled magnitudes
    // ---------------------------------------------------------------------
    logic [MAG_W-1:0] gx_mag, gy_mag;
    logic             s1_valid, s1_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_mag   <= '0;
            gy_mag   <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= win_valid;
            s1_last  <= win_valid & win_last;
            if (win_valid) begin
                gx_mag <= abs_scale(gx);
                gy_mag <= abs_scale(gy);
            end
        end
    end

    // ---------------------------------------------------------------------
    // S2: radicand. 2*127^2 = 32258 < 2^15, so no saturation is needed.
    // ---------------------------------------------------------------------
    logic [SQ_W-1:0] sq_x, sq_y;

    always_comb begin
        sq_x = SQ_W'(gx_mag) * SQ_W'(gx_mag);
        sq_y = SQ_W'(gy_mag) * SQ_W'(gy_mag);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_valid <= 1'b0;
            rad_data  <= '0;
            rad_last  <= 1'b0;
            sof_err   <= 1'b0;
        end else begin
            rad_valid <= s1_valid;
            rad_last  <= s1_valid & s1_last;
            sof_err   <= restart;
            if (s1_valid) begin
                rad_data <= RAD_W'(sq_x) + RAD_W'(sq_y);
            end
        end
    end

endmodule

// File: tb/tb_sobel_grad_sq.sv
module tb_sobel_grad_sq;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid;
  logic        pix_sof;
  logic [7:0]  pix_data;
  logic        rad_valid;
  logic [15:0] rad_data;
  logic        rad_last;
  logic        sof_err;

  sobel_grad_sq #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_data  (pix_data),
    .rad_valid (rad_valid),
    .rad_data  (rad_data),
    .rad_last  (rad_last),
    .sof_err   (sof_err)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // reference image and scoreboard
  int          img[H][W];
  logic [15:0] exp_q[$];
  logic        exp_last_q[$];
  int          exp_cyc_q[$];
  logic [15:0] got_q[$];
  logic [15:0] ref_q[$];

  int n_rad = 0, n_last = 0, n_sof_err = 0, n_16129 = 0, n_nonzero = 0;
  int max_rad = 0, n_bit15 = 0;
  logic [15:0] e_d;
  logic        e_l;
  int          e_c;

  // Reference: Sobel on the whole image with plain integer arithmetic.
  function automatic logic [15:0] model_rad(int cr, int cc);
    int gx, gy, sx, sy;
    gx = (img[cr-1][cc+1] + 2*img[cr][cc+1] + img[cr+1][cc+1])
       - (img[cr-1][cc-1] + 2*img[cr][cc-1] + img[cr+1][cc-1]);
    gy = (img[cr+1][cc-1] + 2*img[cr+1][cc] + img[cr+1][cc+1])
       - (img[cr-1][cc-1] + 2*img[cr-1][cc] + img[cr-1][cc+1]);
    sx = (gx < 0 ? -gx : gx) / 8;
    sy = (gy < 0 ? -gy : gy) / 8;
    return 16'(sx*sx + sy*sy);
  endfunction

  // monitor + scoreboard
  always @(negedge clk) begin
    if (rad_valid === 1'b1) begin
      n_rad++;
      got_q.push_back(rad_data);
      if (rad_last === 1'b1) n_last++;
      if (rad_data == 16'd16129) n_16129++;
      if (rad_data != 16'd0) n_nonzero++;
      if (int'(rad_data) > max_rad) max_rad = int'(rad_data);
      if (rad_data[15]) n_bit15++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected cyc=%0d got data=%0d last=%0b expected no output", cyc, rad_data, rad_last);
      end else begin
        e_d = exp_q.pop_front();
        e_l = exp_last_q.pop_front();
        e_c = exp_cyc_q.pop_front();
        if (rad_data !== e_d || rad_last !== e_l || cyc != e_c) begin
          errors++;
          $display("FAIL sb_rad got data=%0d last=%0b cyc=%0d expected data=%0d last=%0b cyc=%0d",
                   rad_data, rad_last, cyc, e_d, e_l, e_c);
        end
      end
    end
    if (sof_err === 1'b1) n_sof_err++;
  end

  // driver tasks
  task automatic fill(input int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0: img[r][c] = 100;
          1: img[r][c] = (c >= 4) ? 255 : 0;
          2: img[r][c] = (r >= 3) ? 255 : 0;
          3: img[r][c] = (c > r) ? 255 : 0;
          default: img[r][c] = int'($urandom_range(255));
        endcase
  endtask

  task automatic clear_stats();
    n_rad = 0; n_last = 0; n_sof_err = 0; n_16129 = 0; n_nonzero = 0;
    max_rad = 0; n_bit15 = 0;
    got_q.delete();
  endtask

  // Sends pixels (0,0)..(stop_r,stop_c) in raster order, sof on (0,0).
  task automatic send_frame(input int gap_pct, input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r * W + c <= stop_r * W + stop_c) begin
          for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
            @(negedge clk);
            pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 8'($urandom);
          end
          @(negedge clk);
          pix_valid = 1'b1;
          pix_sof   = (r == 0 && c == 0);
          pix_data  = 8'(img[r][c]);
          if (r >= 2 && c >= 2) begin
            exp_q.push_back(model_rad(r - 1, c - 1));
            exp_last_q.push_back(r == H - 1 && c == W - 1);
            exp_cyc_q.push_back(cyc + 3);
          end
        end
      end
    end
    @(negedge clk);
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic drain();
    repeat (5) @(negedge clk);
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (rad_valid !== 1'b0 || rad_last !== 1'b0 || sof_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got valid=%0b last=%0b sof_err=%0b expected 0 0 0", rad_valid, rad_last, sof_err);
    end
    checks++;
    if (rad_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_data got %0d expected 0", rad_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_uniform();
    fill(0); clear_stats();
    send_frame(0, H - 1, W - 1); drain();
    checks++; if (n_rad != 24) begin errors++; $display("FAIL uniform_count got %0d expected 24", n_rad); end
    checks++; if (n_last != 1) begin errors++; $display("FAIL uniform_last got %0d expected 1", n_last); end
    checks++; if (n_nonzero != 0) begin errors++; $display("FAIL uniform_zero got %0d nonzero expected 0", n_nonzero); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL uniform_pending got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_vertical();
    fill(1); clear_stats();
    send_frame(0, H - 1, W - 1); drain();
    checks++; if (n_rad != 24) begin errors++; $display("FAIL vert_count got %0d expected 24", n_rad); end
    checks++; if (n_16129 != 8 || n_nonzero != 8) begin
      errors++; $display("FAIL vert_edges got %0d/%0d expected 8/8", n_16129, n_nonzero);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL vert_pending got %0d expected 0", exp_q.size()); end
    ref_q = got_q;
  endtask

  task automatic test_horizontal();
    fill(2); clear_stats();
    send_frame(0, H - 1, W - 1); drain();
    checks++; if (n_16129 != 12 || n_nonzero != 12) begin
      errors++; $display("FAIL horiz_edges got %0d/%0d expected 12/12", n_16129, n_nonzero);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL horiz_pending got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_diagonal();
    fill(3); clear_stats();
    send_frame(0, H - 1, W - 1); drain();
    checks++; if (max_rad > 32258) begin errors++; $display("FAIL diag_max got %0d expected <= 32258", max_rad); end
    checks++; if (n_bit15 != 0) begin errors++; $display("FAIL diag_bit15 got %0d expected 0", n_bit15); end
    checks++; if (n_rad != 24) begin errors++; $display("FAIL diag_count got %0d expected 24", n_rad); end
  endtask

  task automatic test_gaps();
    fill(1); clear_stats();
    send_frame(30, H - 1, W - 1); drain();
    checks++; if (n_rad != 24) begin errors++; $display("FAIL gaps_count got %0d expected 24", n_rad); end
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) begin
      checks++;
      if (got_q[i] !== ref_q[i]) begin
        errors++; $display("FAIL gaps_seq[%0d] got %0d expected %0d", i, got_q[i], ref_q[i]);
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL gaps_pending got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    fill(4); send_frame(0, H - 1, W - 1);
    fill(4); send_frame(20, H - 1, W - 1);
    drain();
    checks++; if (n_rad != 48) begin errors++; $display("FAIL b2b_count got %0d expected 48", n_rad); end
    checks++; if (n_last != 2) begin errors++; $display("FAIL b2b_last got %0d expected 2", n_last); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_sof_abort();
    fill(4); clear_stats();
    send_frame(0, 3, 2);
    send_frame(0, H - 1, W - 1);
    drain();
    checks++; if (n_sof_err != 1) begin errors++; $display("FAIL abort_sof_err got %0d expected 1", n_sof_err); end
    checks++; if (n_last != 1) begin errors++; $display("FAIL abort_last got %0d expected 1", n_last); end
    checks++; if (n_rad != 31) begin errors++; $display("FAIL abort_count got %0d expected 31", n_rad); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_pending got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_mid_reset();
    fill(1); clear_stats();
    send_frame(0, 2, 5); drain();
    checks++; if (rad_data !== 16'd16129) begin errors++; $display("FAIL mrst_hold got %0d expected 16129", rad_data); end
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++;
    if (rad_valid !== 1'b0 || rad_data !== 16'd0 || rad_last !== 1'b0 || sof_err !== 1'b0) begin
      errors++;
      $display("FAIL mrst_outputs got valid=%0b data=%0d last=%0b sof_err=%0b expected all 0",
               rad_valid, rad_data, rad_last, sof_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 8'($urandom);
    end
    @(negedge clk); pix_valid = 1'b0;
    drain();
    checks++; if (n_rad != 4) begin errors++; $display("FAIL mrst_nosof got %0d outputs expected 4", n_rad); end
    clear_stats();
    fill(4); send_frame(0, H - 1, W - 1); drain();
    checks++; if (n_rad != 24 || n_last != 1) begin
      errors++; $display("FAIL mrst_frame got count=%0d last=%0d expected 24 1", n_rad, n_last);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mrst_pending got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_vertical();
    test_horizontal();
    test_diagonal();
    test_gaps();
    test_back_to_back();
    test_sof_abort();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
